// File: rtl/audio_sequencer_pkg.sv
// audio_sequencer_pkg: sound codes, sequencer states and default sample ROM layout.
package audio_sequencer_pkg;

    typedef enum logic [2:0] {
        SOUND_NONE      = 3'd0,
        SOUND_CHOMP     = 3'd1,
        SOUND_EAT_GHOST = 3'd2,
        SOUND_INTRO     = 3'd3,
        SOUND_DEATH     = 3'd4
    } sound_t;

    typedef enum logic {IDLE, PLAY} seq_state_t;

    localparam int SND_COUNT = 4;
    localparam int SND_START_TBL [SND_COUNT] = '{0, 1600, 3200, 5600};
    localparam int SND_LEN_TBL   [SND_COUNT] = '{1600, 1600, 2400, 2400};

endpackage

// File: rtl/sound_prio_enc.sv
// sound_prio_enc: highest-index set bit of pending wins; any flags a non-empty vector.
module sound_prio_enc #(
    parameter int NUM_SOUNDS = 4,
    parameter int IDX_W      = 2
) (
    input  logic [NUM_SOUNDS-1:0] pending,
    output logic [IDX_W-1:0]      idx,
    output logic                  any
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_SOUNDS; i++)
            if (pending[i]) idx = IDX_W'(i);
    end

    assign any = |pending;

endmodule

// File: rtl/audio_sequencer.sv
// audio_sequencer: latches sound requests, arbitrates by fixed priority and walks the
// winning sound's ROM range one sample per 8 kHz strobe.
module audio_sequencer
    import audio_sequencer_pkg::*;
#(
    parameter int NUM_SOUNDS = 4,
    parameter int ADDR_W     = 13,
    parameter int SOUND_START [NUM_SOUNDS] = SND_START_TBL,
    parameter int SOUND_LEN   [NUM_SOUNDS] = SND_LEN_TBL
) (
    input  logic                  clk_25MHZ,
    input  logic                  rst,
    input  logic                  clk_8KHZ,
    input  logic [NUM_SOUNDS-1:0] req,
    input  logic                  stop,
    output logic [ADDR_W-1:0]     sample_addr,
    output logic                  sample_valid,
    output sound_t                sound_type,
    output logic                  en,
    output logic                  done
);

    localparam int IDX_W = (NUM_SOUNDS > 1) ? $clog2(NUM_SOUNDS) : 1;

    for (genvar i = 0; i < NUM_SOUNDS; i++) begin : g_chk
        if (SOUND_LEN[i] < 1 || SOUND_START[i] + SOUND_LEN[i] - 1 >= (1 << ADDR_W)) begin : g_bad
            $error("audio_sequencer: sound %0d range invalid or exceeds ROM address space", i);
        end
    end

    seq_state_t            state, state_n;
    logic [NUM_SOUNDS-1:0] pending, pending_n;
    logic [ADDR_W-1:0]     addr_n;
    logic [ADDR_W:0]       remaining, rem_n;
    logic                  valid_n, done_n, load, any;
    sound_t                type_n, win_code;
    logic [IDX_W-1:0]      win;

    sound_prio_enc #(.NUM_SOUNDS(NUM_SOUNDS), .IDX_W(IDX_W)) u_prio (
        .pending (pending),
        .idx     (win),
        .any     (any)
    );

    // sound codes are index+1, so comparing codes compares priority
    assign win_code = sound_t'(3'(win) + 3'd1);
    assign en       = (state == PLAY);

    always_ff @(posedge clk_25MHZ or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pending      <= '0;
            sample_addr  <= '0;
            remaining    <= '0;
            sample_valid <= 1'b0;
            sound_type   <= SOUND_NONE;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            pending      <= pending_n;
            sample_addr  <= addr_n;
            remaining    <= rem_n;
            sample_valid <= valid_n;
            sound_type   <= type_n;
            done         <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        pending_n = pending | req;
        addr_n    = sample_addr;
        rem_n     = remaining;
        valid_n   = 1'b0;
        type_n    = sound_type;
        done_n    = 1'b0;
        load      = 1'b0;
        if (stop) begin
            state_n   = IDLE;
            pending_n = '0;
            type_n    = SOUND_NONE;
            rem_n     = '0;
        end else if (state == IDLE) begin
            load = any;
        end else if (clk_8KHZ) begin
            if (any && win_code > sound_type) begin
                load = 1'b1;
            end else if (remaining == 1) begin
                done_n = 1'b1;
                if (any) begin
                    load = 1'b1;
                end else begin
                    state_n = IDLE;
                    type_n  = SOUND_NONE;
                    rem_n   = '0;
                end
            end else begin
                addr_n  = sample_addr + ADDR_W'(1);
                rem_n   = remaining - (ADDR_W+1)'(1);
                valid_n = 1'b1;
            end
        end
        // a grant clears its pending bit unless the same sound is requested again this cycle
        if (load) begin
            state_n        = PLAY;
            type_n         = win_code;
            addr_n         = ADDR_W'(SOUND_START[win]);
            rem_n          = (ADDR_W+1)'(SOUND_LEN[win]);
            valid_n        = 1'b1;
            pending_n[win] = req[win];
        end
    end

endmodule

// File: tb/tb_audio_sequencer.sv
// tb_audio_sequencer: directed checks of arbitration, sequencing, preemption, stop and async reset.
module tb_audio_sequencer;
    import audio_sequencer_pkg::*;

    logic        clk_25MHZ = 1'b0;
    logic        rst = 1'b1;
    logic        clk_8KHZ = 1'b0;
    logic [3:0]  req = '0;
    logic        stop = 1'b0;
    logic [12:0] sample_addr;
    logic        sample_valid;
    sound_t      sound_type;
    logic        en;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    audio_sequencer #(
        .NUM_SOUNDS  (4),
        .ADDR_W      (13),
        .SOUND_START ('{0, 10, 20, 40}),
        .SOUND_LEN   ('{3, 4, 5, 2})
    ) dut (
        .clk_25MHZ    (clk_25MHZ),
        .rst          (rst),
        .clk_8KHZ     (clk_8KHZ),
        .req          (req),
        .stop         (stop),
        .sample_addr  (sample_addr),
        .sample_valid (sample_valid),
        .sound_type   (sound_type),
        .en           (en),
        .done         (done)
    );

    always #20 clk_25MHZ = ~clk_25MHZ;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_25MHZ);
            #1;
        end
    endtask

    task automatic pulse_req(input logic [3:0] v);
        req = v;
        step(1);
        req = '0;
    endtask

    task automatic strobe();
        clk_8KHZ = 1'b1;
        step(1);
        clk_8KHZ = 1'b0;
    endtask

    task automatic gap();
        step(7);
    endtask

    task automatic chk_out(input string tag, input int t, input int a, input int e, input int d);
        chk({tag, ".type"}, int'(sound_type), t);
        chk({tag, ".addr"}, int'(sample_addr), a);
        chk({tag, ".en"},   int'(en), e);
        chk({tag, ".done"}, int'(done), d);
    endtask

    initial begin
        #1;
        chk_out("rst", 0, 0, 0, 0);
        chk("rst.valid", int'(sample_valid), 0);
        step(2);
        rst = 1'b0;
        step(1);

        // 1: single CHOMP
        pulse_req(4'b0001);
        chk("t1.wait_en", int'(en), 0);
        step(1);
        chk_out("t1.load", 1, 0, 1, 0);
        chk("t1.load_valid", int'(sample_valid), 1);
        step(1);
        chk("t1.valid_pulse", int'(sample_valid), 0);
        gap();
        strobe(); chk("t1.a1", int'(sample_addr), 1); chk("t1.v1", int'(sample_valid), 1); gap();
        strobe(); chk("t1.a2", int'(sample_addr), 2); gap();
        strobe(); chk_out("t1.end", 0, 2, 0, 1);
        step(1);
        chk("t1.done_pulse", int'(done), 0);
        gap();

        // 2: CHOMP requeued during its own playback plays again gaplessly
        pulse_req(4'b0001);
        step(1);
        pulse_req(4'b0001);
        gap();
        strobe(); chk("t2.a1", int'(sample_addr), 1); gap();
        strobe(); chk("t2.a2", int'(sample_addr), 2); gap();
        strobe(); chk_out("t2.reload", 1, 0, 1, 1); chk("t2.reload_valid", int'(sample_valid), 1); gap();
        strobe(); gap();
        strobe(); chk("t2.a2b", int'(sample_addr), 2); gap();
        strobe(); chk_out("t2.end", 0, 2, 0, 1); gap();

        // 3: DEATH preempts CHOMP
        pulse_req(4'b0001);
        step(1);
        gap();
        strobe(); chk("t3.a1", int'(sample_addr), 1); gap();
        pulse_req(4'b1000);
        chk("t3.hold_type", int'(sound_type), 1);
        chk("t3.hold_addr", int'(sample_addr), 1);
        gap();
        strobe(); chk_out("t3.preempt", 4, 40, 1, 0); gap();
        strobe(); chk_out("t3.a41", 4, 41, 1, 0); gap();
        strobe(); chk_out("t3.end", 0, 41, 0, 1); gap();
        strobe(); chk("t3.no_resume", int'(en), 0); gap();

        // 4: simultaneous EAT_GHOST and INTRO requests
        pulse_req(4'b0110);
        step(1);
        chk_out("t4.intro", 3, 20, 1, 0);
        gap();
        for (int i = 1; i <= 4; i++) begin
            strobe(); chk("t4.intro_addr", int'(sample_addr), 20 + i); gap();
        end
        strobe(); chk_out("t4.ghost", 2, 10, 1, 1); gap();
        for (int i = 1; i <= 3; i++) begin
            strobe(); chk("t4.ghost_addr", int'(sample_addr), 10 + i); gap();
        end
        strobe(); chk_out("t4.end", 0, 13, 0, 1); gap();

        // 5: stop flushes pending, including a same-cycle request
        pulse_req(4'b0100);
        step(1);
        gap();
        strobe(); chk("t5.a21", int'(sample_addr), 21); gap();
        pulse_req(4'b0010);
        stop = 1'b1;
        req = 4'b0001;
        step(1);
        stop = 1'b0;
        req = '0;
        chk("t5.en", int'(en), 0);
        chk("t5.type", int'(sound_type), 0);
        chk("t5.done", int'(done), 0);
        chk("t5.pending", int'(dut.pending), 0);
        step(3);
        chk("t5.still_idle", int'(en), 0);
        strobe(); chk("t5.no_done", int'(done), 0); gap();

        // 6: asynchronous reset between edges
        pulse_req(4'b0001);
        step(1);
        gap();
        strobe(); chk("t6.a1", int'(sample_addr), 1);
        #5 rst = 1'b1;
        #1;
        chk_out("t6.async", 0, 0, 0, 0);
        chk("t6.valid", int'(sample_valid), 0);
        #2 rst = 1'b0;
        step(1);
        pulse_req(4'b0100);
        step(1);
        chk_out("t6.replay", 3, 20, 1, 0);
        gap();
        strobe(); chk("t6.a21", int'(sample_addr), 21);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
